// File: rtl/nios_system_mul_sequencer_if.sv
// Request/response handshake bundle between the multiply front end and the sequencer.
interface nios_system_mul_sequencer_if #(
  parameter int ID_W = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            req_op;
  logic [ID_W-1:0] req_tag;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [ID_W-1:0] rsp_tag;
  logic            rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/nios_system_mul_sequencer.sv
// Sequences 32x32 unsigned multiplies over a three-partial-product 16x16 cell.
// MUL_SEQ_HIGH_WORD_EN adds the second cell pass that produces the upper product word.
//   state    | meaning
//   IDLE     | ready for a request
//   ISSUE    | full operands to cell, cell_en high
//   CAPT     | fold p1..p3 into the low word / high carry
//   HI_ISSUE | hi(A), hi(B) to cell, cell_en high
//   HI_CAPT  | upper word = hi*hi + carry
//   RESP     | hold response until rsp_ready
module nios_system_mul_sequencer #(
  parameter int ID_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_system_mul_sequencer_if.slave  bus,
  output logic [31:0]                 cell_src1,
  output logic [31:0]                 cell_src2,
  output logic                        cell_en,
  input  logic [31:0]                 cell_p1,
  input  logic [31:0]                 cell_p2,
  input  logic [31:0]                 cell_p3,
  output logic                        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_CAPT     = 3'd2;
`ifdef MUL_SEQ_HIGH_WORD_EN
  localparam logic [2:0] S_HI_ISSUE = 3'd3;
  localparam logic [2:0] S_HI_CAPT  = 3'd4;
`endif
  localparam logic [2:0] S_RESP     = 3'd5;

  logic [2:0]      state;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [31:0]     data_q;
  logic [ID_W-1:0] tag_q;

`ifdef MUL_SEQ_HIGH_WORD_EN
  logic        op_q;
  logic [16:0] acc_hi_q;
  logic [32:0] mid;
  logic [48:0] acc_next;

  assign mid      = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign acc_next = {mid, 16'h0000} + {17'h00000, cell_p1};
  assign bus.rsp_err = 1'b0;
`else
  logic        err_q;
  logic [31:0] lo_word;

  // Only the low word is needed here, so the sum can wrap at 32 bits.
  assign lo_word = cell_p1 + ((cell_p2 + cell_p3) << 16);
  assign bus.rsp_err = err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      tag_q    <= '0;
`ifdef MUL_SEQ_HIGH_WORD_EN
      op_q     <= 1'b0;
      acc_hi_q <= '0;
`else
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            tag_q  <= bus.req_tag;
            data_q <= '0;
`ifdef MUL_SEQ_HIGH_WORD_EN
            op_q   <= bus.req_op;
            state  <= S_ISSUE;
`else
            // High-word requests are answered immediately with an error.
            err_q  <= bus.req_op;
            state  <= bus.req_op ? S_RESP : S_ISSUE;
`endif
          end
        end
        S_ISSUE: state <= S_CAPT;
        S_CAPT: begin
`ifdef MUL_SEQ_HIGH_WORD_EN
          acc_hi_q <= acc_next[48:32];
          if (op_q) begin
            state <= S_HI_ISSUE;
          end else begin
            data_q <= acc_next[31:0];
            state  <= S_RESP;
          end
`else
          data_q <= lo_word;
          state  <= S_RESP;
`endif
        end
`ifdef MUL_SEQ_HIGH_WORD_EN
        S_HI_ISSUE: state <= S_HI_CAPT;
        S_HI_CAPT: begin
          data_q <= cell_p1 + {15'h0000, acc_hi_q};
          state  <= S_RESP;
        end
`endif
        S_RESP: if (bus.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cell_src1 = '0;
    cell_src2 = '0;
    cell_en   = 1'b0;
    case (state)
      S_ISSUE: begin
        cell_src1 = a_q;
        cell_src2 = b_q;
        cell_en   = 1'b1;
      end
`ifdef MUL_SEQ_HIGH_WORD_EN
      S_HI_ISSUE: begin
        cell_src1 = {16'h0000, a_q[31:16]};
        cell_src2 = {16'h0000, b_q[31:16]};
        cell_en   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.req_ready = (state == S_IDLE) & ~reset;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_tag   = tag_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_nios_system_mul_sequencer.sv
// Scoreboard bench for nios_system_mul_sequencer with a behavioural multiplier-cell model.
module tb_nios_system_mul_sequencer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          lat;
    int          en;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;
  logic        cell_en, busy;
  logic        bp_rand = 1'b0;
  logic        man_ready = 1'b1;
  logic        rnd_ready = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  bit          in_resp = 0;
  logic [31:0] snap_data;
  logic [3:0]  snap_tag;
  logic        snap_err;
  exp_t        q[$];

  nios_system_mul_sequencer_if #(.ID_W(4)) bus();

  nios_system_mul_sequencer #(.ID_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));
  assign bus.rsp_ready = bp_rand ? rnd_ready : man_ready;

  // Multiplier cell: registered 16x16 partial products.
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
      cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
      cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input logic [3:0] tag);
    exp_t e;
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    e.tag = tag;
    e.acc_cyc = 0;
`ifdef MUL_SEQ_HIGH_WORD_EN
    e.data = op ? p[63:32] : p[31:0];
    e.err  = 1'b0;
    e.lat  = op ? 5 : 3;
    e.en   = op ? 2 : 1;
`else
    e.data = op ? 32'h0 : p[31:0];
    e.err  = op;
    e.lat  = op ? 1 : 3;
    e.en   = op ? 0 : 1;
`endif
    return e;
  endfunction

  // Monitor: checks latency, hold stability and payload against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      in_resp = 0;
      en_cnt  = 0;
    end else begin
      if (cell_en) en_cnt++;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp_queue", 64'(q.size()), 64'd1);
        end else begin
          if (!in_resp) begin
            chk("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
            in_resp   = 1;
            snap_data = bus.rsp_data;
            snap_tag  = bus.rsp_tag;
            snap_err  = bus.rsp_err;
          end else begin
            chk("hold_data", 64'(bus.rsp_data), 64'(snap_data));
            chk("hold_tag", 64'(bus.rsp_tag), 64'(snap_tag));
            chk("hold_err", 64'(bus.rsp_err), 64'(snap_err));
          end
          chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
          chk("cell_en_in_resp", 64'(cell_en), 64'd0);
          if (bus.rsp_ready) begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            chk("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
            chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            chk("cell_en_pulses", 64'(en_cnt), 64'(e.en));
            en_cnt  = 0;
            in_resp = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [3:0] tag, input bit push, output int acc_cyc);
    exp_t e;
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = op;
    bus.req_tag = tag;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e = model(a, b, op, tag);
    e.acc_cyc = cyc;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    bus.req_op = 1'($urandom_range(0, 1));
    bus.req_tag = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc, n;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = 1'b0;
    bus.req_tag = '0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    chk("rst_cell_en", 64'(cell_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    send(32'd3, 32'd5, 1'b0, 4'd2, 1, n_acc);
    drain();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd1, 1, n_acc);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd3, 1, n_acc);
    send(32'h0001_0000, 32'h0001_0000, 1'b0, 4'd4, 1, n_acc);
    send(32'h0001_0000, 32'h0001_0000, 1'b1, 4'd6, 1, n_acc);
    send(32'd2, 32'd2, 1'b1, 4'd5, 1, n_acc);
    drain();

    // Backpressure: response held 6 cycles.
    man_ready = 1'b0;
    send(32'd7, 32'd6, 1'b0, 4'hA, 1, n_acc);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_ready", 64'(bus.req_ready), 64'd1);

    // Reset in the last capture state of a long operation.
`ifdef MUL_SEQ_HIGH_WORD_EN
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h9, 0, n_acc);
    while (cyc < n_acc + 4) @(negedge clk);
`else
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h9, 0, n_acc);
    while (cyc < n_acc + 2) @(negedge clk);
`endif
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tag", 64'(bus.rsp_tag), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_src", 64'({cell_src1, cell_src2}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_rsp_after_reset", 64'(bus.rsp_valid), 64'd0);
    send(32'd7, 32'd6, 1'b0, 4'h3, 1, n_acc);
    drain();

    // Randomized traffic with random backpressure and back-to-back requests.
    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 : $urandom;
      send(ra, rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1, n_acc);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    bp_rand = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
